seg_display_arbiter: RTL and testbench

//   Shares the 8-digit, two-bank 7-segment display among three time sources:

---
 rtl/seg_display_arbiter_if.sv | 24 ++
 rtl/seg_display_arbiter.sv | 153 +++++++++++++++
 tb/tb_seg_display_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// Bus bundle between the display arbiter and its time/edit/alarm sources
// plus the segment pad drivers.
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [7:0]  blink_mask;
  logic [2:0]  gnt;
  logic        gnt_chg;
  logic [7:0]  seg_data;
  logic [7:0]  seg_data2;
  logic [7:0]  seg_cs;

  modport master (
    output req, data0, data1, data2, blink_mask,
    input  gnt, gnt_chg, seg_data, seg_data2, seg_cs
  );

  modport slave (
    input  req, data0, data1, data2, blink_mask,
    output gnt, gnt_chg, seg_data, seg_data2, seg_cs
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner arbitration with minimum hold, two-bank 4-slot scan,
// editor field blink and nibble-to-7-segment decode for an 8-digit display.
module seg_display_arbiter #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000,
  parameter int MIN_HOLD  = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_display_arbiter_if.slave  bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // One extra code point so the counter can actually rest at MIN_HOLD.
  localparam int HOLD_W  = (MIN_HOLD  > 0) ? $clog2(MIN_HOLD + 1) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MIN_HOLD);

  localparam logic [2:0] GNT_NONE  = 3'b000;
  localparam logic [2:0] GNT_CLK   = 3'b001;
  localparam logic [2:0] GNT_EDIT  = 3'b010;
  localparam logic [2:0] GNT_ALARM = 3'b100;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 8'hFC;
      4'h1:    seg_decode = 8'h60;
      4'h2:    seg_decode = 8'hDA;
      4'h3:    seg_decode = 8'hF2;
      4'h4:    seg_decode = 8'h66;
      4'h5:    seg_decode = 8'hB6;
      4'h6:    seg_decode = 8'hBE;
      4'h7:    seg_decode = 8'hE0;
      4'h8:    seg_decode = 8'hFE;
      4'h9:    seg_decode = 8'hF6;
      4'hF:    seg_decode = 8'h02;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] h);
    hold_sat_inc = (h >= HOLD_MAX) ? HOLD_MAX : h + HOLD_W'(1);
  endfunction

  logic [2:0]         gnt_p1;
  logic               gnt_chg_p1;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;
  logic [7:0]         seg_data_p1;
  logic [7:0]         seg_data2_p1;
  logic [7:0]         seg_cs_p1;

  logic [2:0]  top_req_p0;
  logic [2:0]  gnt_nxt_p0;
  logic        higher_p0;
  logic [31:0] src_p0;
  logic [3:0]  nib_hi_p0;
  logic [3:0]  nib_lo_p0;
  logic        blink_on_p0;
  logic        blank_hi_p0;
  logic        blank_lo_p0;
  logic [7:0]  seg_hi_p0;
  logic [7:0]  seg_lo_p0;
  logic [7:0]  cs_p0;

  // Stage p0: arbitration decision and segment decode from registered state
  always_comb begin
    top_req_p0 = GNT_NONE;
    if (bus.req[2])      top_req_p0 = GNT_ALARM;
    else if (bus.req[1]) top_req_p0 = GNT_EDIT;
    else if (bus.req[0]) top_req_p0 = GNT_CLK;

    case (gnt_p1)
      GNT_CLK:  higher_p0 = bus.req[2] | bus.req[1];
      GNT_EDIT: higher_p0 = bus.req[2];
      default:  higher_p0 = 1'b0;
    endcase

    gnt_nxt_p0 = gnt_p1;
    if (gnt_p1 == GNT_NONE || (bus.req & gnt_p1) == 3'b000)
      gnt_nxt_p0 = top_req_p0;
    else if (higher_p0 && hold_cnt >= HOLD_MAX)
      gnt_nxt_p0 = top_req_p0;
  end

  always_comb begin
    case (gnt_p1)
      GNT_CLK:   src_p0 = bus.data0;
      GNT_EDIT:  src_p0 = bus.data1;
      GNT_ALARM: src_p0 = bus.data2;
      default:   src_p0 = 32'h0;
    endcase
    nib_hi_p0   = src_p0[{1'b1, idx, 2'b00} +: 4];
    nib_lo_p0   = src_p0[{1'b0, idx, 2'b00} +: 4];
    blink_on_p0 = (gnt_p1 == GNT_EDIT) && blink_ph;
    blank_hi_p0 = blink_on_p0 && bus.blink_mask[{1'b1, idx}];
    blank_lo_p0 = blink_on_p0 && bus.blink_mask[{1'b0, idx}];
    seg_hi_p0   = (gnt_p1 == GNT_NONE || blank_hi_p0) ? 8'h00 : seg_decode(nib_hi_p0);
    seg_lo_p0   = (gnt_p1 == GNT_NONE || blank_lo_p0) ? 8'h00 : seg_decode(nib_lo_p0);
    cs_p0       = {4'b0001 << idx, 4'b0001 << idx};
  end

  // Stage p1: registered grant, counters and pad outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_p1       <= GNT_NONE;
      gnt_chg_p1   <= 1'b0;
      hold_cnt     <= '0;
      scan_cnt     <= '0;
      idx          <= 2'd0;
      blink_cnt    <= '0;
      blink_ph     <= 1'b0;
      seg_data_p1  <= 8'h00;
      seg_data2_p1 <= 8'h00;
      seg_cs_p1    <= 8'h00;
    end else begin
      gnt_p1     <= gnt_nxt_p0;
      gnt_chg_p1 <= (gnt_nxt_p0 != gnt_p1);
      hold_cnt   <= (gnt_nxt_p0 != gnt_p1) ? '0 : hold_sat_inc(hold_cnt);

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      seg_data_p1  <= seg_hi_p0;
      seg_data2_p1 <= seg_lo_p0;
      seg_cs_p1    <= cs_p0;
    end
  end

  assign bus.gnt       = gnt_p1;
  assign bus.gnt_chg   = gnt_chg_p1;
  assign bus.seg_data  = seg_data_p1;
  assign bus.seg_data2 = seg_data2_p1;
  assign bus.seg_cs    = seg_cs_p1;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboarded bench for seg_display_arbiter: a cycle model queues the expected
// outputs at every clock edge, and each scenario pops and compares them.
module tb_seg_display_arbiter;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int MIN_HOLD  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_arbiter_if bus();

  seg_display_arbiter #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV),
    .MIN_HOLD (MIN_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [27:0] sb[$];
  logic [27:0] act_v, exp_v;

  // Reference model state
  logic [2:0] m_gnt  = 3'b000;
  int         m_hold = 0;
  int         m_scan = 0;
  int         m_idx  = 0;
  int         m_bcnt = 0;
  logic       m_ph   = 1'b0;
  logic [2:0]  m_ng;
  logic [27:0] m_exp;

  function automatic logic [7:0] ref_dec(input logic [3:0] n);
    case (n)
      4'd0: return 8'hFC;  4'd1: return 8'h60;  4'd2: return 8'hDA;
      4'd3: return 8'hF2;  4'd4: return 8'h66;  4'd5: return 8'hB6;
      4'd6: return 8'hBE;  4'd7: return 8'hE0;  4'd8: return 8'hFE;
      4'd9: return 8'hF6;  4'hF: return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] ref_top(input logic [2:0] r);
    for (int b = 2; b >= 0; b--) if (r[b]) return 3'(1 << b);
    return 3'b000;
  endfunction

  function automatic logic [2:0] ref_next(input logic [2:0] g, input int h, input logic [2:0] r);
    if (g == 3'b000 || (r & g) == 3'b000) return ref_top(r);
    if ({1'b0, r} >= {g, 1'b0} && h >= MIN_HOLD) return ref_top(r);
    return g;
  endfunction

  function automatic logic [23:0] ref_seg(input logic [2:0] g, input int ix, input logic ph,
                                          input logic [31:0] d0, input logic [31:0] d1,
                                          input logic [31:0] d2, input logic [7:0] mask);
    logic [31:0] d;
    logic [7:0]  hi, lo, cs;
    d  = (g == 3'b001) ? d0 : (g == 3'b010) ? d1 : (g == 3'b100) ? d2 : 32'h0;
    hi = ref_dec(4'((d >> (4 * (ix + 4))) & 32'hF));
    lo = ref_dec(4'((d >> (4 * ix)) & 32'hF));
    if (g == 3'b000) begin hi = 8'h00; lo = 8'h00; end
    if (g == 3'b010 && ph && mask[ix + 4]) hi = 8'h00;
    if (g == 3'b010 && ph && mask[ix])     lo = 8'h00;
    cs = 8'((1 << (ix + 4)) | (1 << ix));
    return {hi, lo, cs};
  endfunction

  assign m_ng  = ref_next(m_gnt, m_hold, bus.req);
  assign m_exp = {m_ng, m_ng != m_gnt,
                  ref_seg(m_gnt, m_idx, m_ph, bus.data0, bus.data1, bus.data2, bus.blink_mask)};

  always @(posedge clk) begin
    if (rst) begin
      sb.push_back(28'h0);
      m_gnt <= 3'b000; m_hold <= 0; m_scan <= 0; m_idx <= 0; m_bcnt <= 0; m_ph <= 1'b0;
    end else begin
      sb.push_back(m_exp);
      m_gnt  <= m_ng;
      m_hold <= (m_ng != m_gnt) ? 0 : ((m_hold >= MIN_HOLD) ? MIN_HOLD : m_hold + 1);
      m_scan <= (m_scan + 1) % SCAN_DIV;
      if (m_scan == SCAN_DIV - 1) m_idx <= (m_idx + 1) % 4;
      m_bcnt <= (m_bcnt + 1) % BLINK_DIV;
      if (m_bcnt == BLINK_DIV - 1) m_ph <= ~m_ph;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      act_v = {bus.gnt, bus.gnt_chg, bus.seg_data, bus.seg_data2, bus.seg_cs};
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL sb_empty_reset cyc=%0d", c); end
      else begin
        exp_v = sb.pop_front();
        if (act_v !== exp_v) begin
          failures++; $display("FAIL sb_reset cyc=%0d actual=%h required=%h", c, act_v, exp_v);
        end
      end
      checks++;
      if (act_v !== 28'h0) begin
        failures++; $display("FAIL reset_outputs cyc=%0d actual=%h required=0000000", c, act_v);
      end
    end
  endtask

  task automatic test_grant_and_hold();
    bus.data0 = 32'h12F34F56;
    bus.data1 = 32'h88888888;
    bus.req   = 3'b001;
    rst       = 1'b0;
    sb.delete();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      act_v = {bus.gnt, bus.gnt_chg, bus.seg_data, bus.seg_data2, bus.seg_cs};
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL sb_empty_grant cyc=%0d", c); end
      else begin
        exp_v = sb.pop_front();
        if (act_v !== exp_v) begin
          failures++; $display("FAIL sb_grant cyc=%0d actual=%h required=%h", c, act_v, exp_v);
        end
      end
      if (c == 0) begin
        checks++;
        if (bus.gnt !== 3'b001 || bus.gnt_chg !== 1'b1) begin
          failures++; $display("FAIL grant_first actual gnt=%b chg=%b required gnt=001 chg=1", bus.gnt, bus.gnt_chg);
        end
      end
      if (c == 1) begin
        checks++;
        if (bus.gnt_chg !== 1'b0 || bus.seg_cs !== 8'h11 || bus.seg_data !== 8'hF2 || bus.seg_data2 !== 8'hBE) begin
          failures++; $display("FAIL slot0 actual chg=%b cs=%h seg=%h seg2=%h required chg=0 cs=11 seg=f2 seg2=be",
                               bus.gnt_chg, bus.seg_cs, bus.seg_data, bus.seg_data2);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.seg_cs !== 8'h22 || bus.seg_data !== 8'h02 || bus.seg_data2 !== 8'hB6) begin
          failures++; $display("FAIL slot1 actual cs=%h seg=%h seg2=%h required cs=22 seg=02 seg2=b6",
                               bus.seg_cs, bus.seg_data, bus.seg_data2);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.gnt !== 3'b001) begin
          failures++; $display("FAIL hold_keeps actual gnt=%b required 001", bus.gnt);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.gnt !== 3'b010 || bus.gnt_chg !== 1'b1) begin
          failures++; $display("FAIL preempt_after_hold actual gnt=%b chg=%b required gnt=010 chg=1", bus.gnt, bus.gnt_chg);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.seg_cs !== 8'h44 || bus.seg_data !== 8'hFE || bus.seg_data2 !== 8'hFE) begin
          failures++; $display("FAIL slot2_editor actual cs=%h seg=%h seg2=%h required cs=44 seg=fe seg2=fe",
                               bus.seg_cs, bus.seg_data, bus.seg_data2);
        end
      end
      if (c == 2) bus.req = 3'b011;
    end
  endtask

  task automatic test_release();
    bus.req = 3'b001;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      act_v = {bus.gnt, bus.gnt_chg, bus.seg_data, bus.seg_data2, bus.seg_cs};
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL sb_empty_release cyc=%0d", c); end
      else begin
        exp_v = sb.pop_front();
        if (act_v !== exp_v) begin
          failures++; $display("FAIL sb_release cyc=%0d actual=%h required=%h", c, act_v, exp_v);
        end
      end
      if (c == 0) begin
        checks++;
        if (bus.gnt !== 3'b001 || bus.gnt_chg !== 1'b1) begin
          failures++; $display("FAIL release_to_lower actual gnt=%b chg=%b required gnt=001 chg=1", bus.gnt, bus.gnt_chg);
        end
        bus.req = 3'b000;
      end
      if (c == 1) begin
        checks++;
        if (bus.gnt !== 3'b000 || bus.gnt_chg !== 1'b1) begin
          failures++; $display("FAIL release_to_none actual gnt=%b chg=%b required gnt=000 chg=1", bus.gnt, bus.gnt_chg);
        end
      end
      if (c >= 2) begin
        checks++;
        if (bus.seg_data !== 8'h00 || bus.seg_data2 !== 8'h00 || bus.gnt_chg !== 1'b0 ||
            bus.seg_cs[7:4] !== bus.seg_cs[3:0] || !$onehot(bus.seg_cs[3:0])) begin
          failures++; $display("FAIL idle_blank cyc=%0d actual seg=%h seg2=%h cs=%h chg=%b required seg=00 seg2=00 scanning cs chg=0",
                               c, bus.seg_data, bus.seg_data2, bus.seg_cs, bus.gnt_chg);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] prev;
    int last_c;
    int nchg;
    last_c = -1;
    nchg   = 0;
    prev   = 8'h00;
    bus.req        = 3'b011;
    bus.blink_mask = 8'h0F;
    bus.data1      = 32'h88888888;
    sb.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      act_v = {bus.gnt, bus.gnt_chg, bus.seg_data, bus.seg_data2, bus.seg_cs};
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL sb_empty_blink cyc=%0d", c); end
      else begin
        exp_v = sb.pop_front();
        if (act_v !== exp_v) begin
          failures++; $display("FAIL sb_blink cyc=%0d actual=%h required=%h", c, act_v, exp_v);
        end
      end
      if (c >= 1) begin
        checks++;
        if (bus.gnt !== 3'b010 || bus.seg_data !== 8'hFE || (bus.seg_data2 !== 8'hFE && bus.seg_data2 !== 8'h00)) begin
          failures++; $display("FAIL blink_left cyc=%0d actual gnt=%b seg=%h seg2=%h required gnt=010 seg=fe seg2=fe/00",
                               c, bus.gnt, bus.seg_data, bus.seg_data2);
        end
        if (c >= 2 && bus.seg_data2 !== prev) begin
          nchg++;
          if (last_c >= 0) begin
            checks++;
            if (c - last_c != BLINK_DIV) begin
              failures++; $display("FAIL blink_period actual=%0d required=%0d", c - last_c, BLINK_DIV);
            end
          end
          last_c = c;
        end
        prev = bus.seg_data2;
      end
    end
    checks++;
    if (nchg < 4) begin
      failures++; $display("FAIL blink_toggles actual=%0d required>=4", nchg);
    end
  endtask

  task automatic test_decode();
    bus.data2 = 32'hBBBBFFFF;
    bus.req   = 3'b100;
    sb.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      act_v = {bus.gnt, bus.gnt_chg, bus.seg_data, bus.seg_data2, bus.seg_cs};
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL sb_empty_decode cyc=%0d", c); end
      else begin
        exp_v = sb.pop_front();
        if (act_v !== exp_v) begin
          failures++; $display("FAIL sb_decode cyc=%0d actual=%h required=%h", c, act_v, exp_v);
        end
      end
      if (c == 0) begin
        checks++;
        if (bus.gnt !== 3'b100 || bus.gnt_chg !== 1'b1) begin
          failures++; $display("FAIL preempt_saturated actual gnt=%b chg=%b required gnt=100 chg=1", bus.gnt, bus.gnt_chg);
        end
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (bus.seg_data !== 8'h00 || bus.seg_data2 !== 8'h02) begin
          failures++; $display("FAIL decode_blank_dash cyc=%0d actual seg=%h seg2=%h required seg=00 seg2=02",
                               c, bus.seg_data, bus.seg_data2);
        end
      end
      if (c == 8)  bus.data2 = 32'h01234567;
      if (c == 13) bus.data2 = 32'h89ABCDEF;
    end
  endtask

  task automatic test_mid_reset();
    int hit;
    hit = 0;
    sb.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      act_v = {bus.gnt, bus.gnt_chg, bus.seg_data, bus.seg_data2, bus.seg_cs};
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL sb_empty_midreset cyc=%0d", c); end
      else begin
        exp_v = sb.pop_front();
        if (act_v !== exp_v) begin
          failures++; $display("FAIL sb_midreset cyc=%0d actual=%h required=%h", c, act_v, exp_v);
        end
      end
      if (hit == 2) begin
        checks++;
        if (bus.seg_cs !== 8'h11 || bus.gnt !== 3'b100) begin
          failures++; $display("FAIL reset_idx0 actual cs=%h gnt=%b required cs=11 gnt=100", bus.seg_cs, bus.gnt);
        end
        hit = 3;
      end else if (hit == 1) begin
        checks++;
        if (act_v !== 28'h0) begin
          failures++; $display("FAIL mid_reset_zero actual=%h required=0000000", act_v);
        end
        rst = 1'b0;
        hit = 2;
      end else if (hit == 0 && bus.seg_cs == 8'h44) begin
        rst = 1'b1;
        hit = 1;
      end
    end
    checks++;
    if (hit != 3) begin
      failures++; $display("FAIL mid_reset_timeout actual stage=%0d required=3", hit);
    end
  endtask

  initial begin
    bus.req        = 3'b000;
    bus.data0      = 32'h0;
    bus.data1      = 32'h0;
    bus.data2      = 32'h0;
    bus.blink_mask = 8'h00;
    test_reset();
    test_grant_and_hold();
    test_release();
    test_blink();
    test_decode();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
